// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 SEQ definitions: instruction codes, processor
//               status codes, stage-sequencer state encoding, OPq ALU
//               function codes and icode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Processor status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // OPq function codes (ifun field)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_PCUP   = 4'd6,
    ST_HALT   = 4'd7,
    ST_FAULT  = 4'd8
  } state_t;

  // Instructions that touch data memory
  function automatic logic is_mem_icode(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) ||
           (ic == IRET)    || (ic == IPUSHQ)  || (ic == IPOPQ);
  endfunction

  // Memory instructions that store rather than load
  function automatic logic is_mem_write(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_stage_ctrl_if
// Description : Memory handshake bundle between the stage sequencer and the
//               fetch / data-memory side.
//   imem_ready, icode, ifun, instr_valid, imem_err : fetch result + handshake
//   dmem_ready, dmem_err                           : data-memory completion
//   mem_req, mem_we                                : data-memory request
//   master : sequencer side, slave : memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_stage_ctrl_if;
  logic       imem_ready;
  logic [3:0] icode;
  logic [3:0] ifun;
  logic       instr_valid;
  logic       imem_err;
  logic       dmem_ready;
  logic       dmem_err;
  logic       mem_req;
  logic       mem_we;

  modport master (
    input  imem_ready, icode, ifun, instr_valid, imem_err, dmem_ready, dmem_err,
    output mem_req, mem_we
  );

  modport slave (
    output imem_ready, icode, ifun, instr_valid, imem_err, dmem_ready, dmem_err,
    input  mem_req, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/seq_stage_ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_wait_timer
// Description : Ready-wait timer shared by the fetch and data-memory waits.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold the count at zero (asserted outside the wait states)
//   enable     : this cycle is a waiting cycle (request up, no ready)
//   expired    : this waiting cycle is the TIMEOUT-th one
// Revision    : 1.0 - initial release
// ============================================================================
module seq_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);

  // count_q holds the number of waiting cycles already completed, so the
  // current waiting cycle is the last allowed one when it equals TIMEOUT-1.
  localparam logic [TO_W-1:0] C_LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;
  logic            at_limit;

  assign at_limit = (count_q == C_LIMIT);
  assign expired  = enable && at_limit;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !at_limit) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_stage_ctrl
// Description : Stage sequencer for the Y86-64 SEQ core. Steps one stage per
//               state, issues stage enables, waits on memory handshakes,
//               owns the status code and the retired-instruction counter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : leave IDLE
//   bus (master)        : fetch / data-memory handshake bundle
//   *_en, cc_en         : stage enables (decoded from state)
//   icode_q, ifun_q     : latched instruction codes
//   stat, busy, retired : status, activity flag, completed-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  seq_stage_ctrl_if.master       bus,
  output logic                   fetch_en,
  output logic                   decode_en,
  output logic                   exec_en,
  output logic                   wb_en,
  output logic                   pc_en,
  output logic                   cc_en,
  output logic [3:0]             icode_q,
  output logic [3:0]             ifun_q,
  output logic [2:0]             stat,
  output logic                   busy,
  output logic [31:0]            retired
);

  state_t      state_q, state_d;
  logic [2:0]  stat_q, stat_d;
  logic [3:0]  icode_d, ifun_d;
  logic [31:0] retired_q, retired_d;
  logic        wait_clear, wait_en, wait_expired;

  // The timer runs only while a FETCH or MEM request is outstanding and is
  // held at zero everywhere else, which clears it on every entry.
  assign wait_clear = !((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign wait_en    = ((state_q == ST_FETCH) && !bus.imem_ready) ||
                      ((state_q == ST_MEM)   && !bus.dmem_ready);

  seq_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wait_clear),
    .enable  (wait_en),
    .expired (wait_expired)
  );

  assign fetch_en    = (state_q == ST_FETCH);
  assign decode_en   = (state_q == ST_DECODE);
  assign exec_en     = (state_q == ST_EXEC);
  assign wb_en       = (state_q == ST_WB);
  assign pc_en       = (state_q == ST_PCUP);
  assign bus.mem_req = (state_q == ST_MEM);
  assign bus.mem_we  = bus.mem_req && is_mem_write(icode_q);
  assign cc_en       = exec_en && (icode_q == IOPQ);
  assign busy        = fetch_en || decode_en || exec_en || bus.mem_req || wb_en || pc_en;
  assign stat        = stat_q;
  assign retired     = retired_q;

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    icode_d   = icode_q;
    ifun_d    = ifun_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Ready is checked before the timer so a same-edge ready wins.
        if (bus.imem_ready) begin
          icode_d = bus.icode;
          ifun_d  = bus.ifun;
          if (bus.imem_err) begin
            state_d = ST_FAULT;
            stat_d  = STAT_ADR;
          end else if (!bus.instr_valid || (bus.icode > IPOPQ)) begin
            state_d = ST_FAULT;
            stat_d  = STAT_INS;
          end else if (bus.icode == IHALT) begin
            state_d = ST_HALT;
            stat_d  = STAT_HLT;
          end else begin
            state_d = ST_DECODE;
          end
        end else if (wait_expired) begin
          state_d = ST_FAULT;
          stat_d  = STAT_ADR;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_mem_icode(icode_q)) begin
          state_d = ST_MEM;
        end else if ((icode_q == IJXX) || (icode_q == INOP)) begin
          state_d = ST_PCUP;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.dmem_ready) begin
          if (bus.dmem_err) begin
            state_d = ST_FAULT;
            stat_d  = STAT_ADR;
          end else if (icode_q == IRMMOVQ) begin
            state_d = ST_PCUP;   // a store has no register write-back
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_expired) begin
          state_d = ST_FAULT;
          stat_d  = STAT_ADR;
        end
      end
      ST_WB: state_d = ST_PCUP;
      ST_PCUP: begin
        if (retired_q != 32'hFFFF_FFFF) retired_d = retired_q + 32'd1;
        state_d = ST_FETCH;
      end
      ST_HALT, ST_FAULT: state_d = state_q;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stat_q    <= STAT_AOK;
      icode_q   <= 4'h0;
      ifun_q    <= 4'h0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      icode_q   <= icode_d;
      ifun_q    <= ifun_d;
      retired_q <= retired_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_stage_ctrl
// Description : Self-checking bench for seq_stage_ctrl. A per-instruction
//               reference model builds the expected stage trace from the
//               instruction class and the memory wait lengths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_stage_ctrl;

  localparam int TMO = 4;
  localparam int TW  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        fetch_en, decode_en, exec_en, wb_en, pc_en, cc_en, busy;
  logic [3:0]  icode_q, ifun_q;
  logic [2:0]  stat;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  int         exp_retired;
  logic [2:0] exp_stat;
  logic [3:0] exp_icode, exp_ifun;

  seq_stage_ctrl_if bus ();

  seq_stage_ctrl #(.TIMEOUT(TMO), .TO_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .fetch_en  (fetch_en),
    .decode_en (decode_en),
    .exec_en   (exec_en),
    .wb_en     (wb_en),
    .pc_en     (pc_en),
    .cc_en     (cc_en),
    .icode_q   (icode_q),
    .ifun_q    (ifun_q),
    .stat      (stat),
    .busy      (busy),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Observed stage letter from the one-hot enable set; '?' if several are high.
  function automatic byte obs_stage();
    int n;
    byte s;
    n = int'(fetch_en) + int'(decode_en) + int'(exec_en) + int'(bus.mem_req) +
        int'(wb_en) + int'(pc_en);
    s = "-";
    if (fetch_en)    s = "F";
    if (decode_en)   s = "D";
    if (exec_en)     s = "E";
    if (bus.mem_req) s = "M";
    if (wb_en)       s = "W";
    if (pc_en)       s = "P";
    if (n > 1)       s = "?";
    return s;
  endfunction

  // Reset the DUT and the model, then pulse start so the DUT is in FETCH.
  task automatic apply_reset_start();
    start = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_retired = 0; exp_stat = 3'd1; exp_icode = 4'h0; exp_ifun = 4'h0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one instruction from FETCH entry. iw/dw: cycles without ready before
  // ready (>= TMO means ready never comes). abort_at: trace index at which
  // reset is asserted, -1 for none.
  task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn,
                           input bit valid, input bit ierr, input bit derr,
                           input int iw, input int dw, input int abort_at);
    byte        exp_q[$];
    bit         retire = 1'b0;
    bit         term   = 1'b0;
    logic [2:0] nstat  = exp_stat;
    int         mi     = 0;
    byte        stg;
    logic [2:0] exp_aux, got_aux;

    // ---- reference model: expected stage sequence ----
    for (int i = 0; i < ((iw >= TMO) ? TMO : iw + 1); i++) exp_q.push_back("F");
    if (iw >= TMO) begin
      term = 1'b1; nstat = 3'd3;
    end else if (ierr) begin
      term = 1'b1; nstat = 3'd3;
    end else if (!valid || ic > 4'hB) begin
      term = 1'b1; nstat = 3'd4;
    end else if (ic == 4'h0) begin
      term = 1'b1; nstat = 3'd2;
    end else begin
      exp_q.push_back("D");
      exp_q.push_back("E");
      if (ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
        for (int i = 0; i < ((dw >= TMO) ? TMO : dw + 1); i++) exp_q.push_back("M");
        if (dw >= TMO || derr) begin
          term = 1'b1; nstat = 3'd3;
        end else begin
          if (ic != 4'h4) exp_q.push_back("W");
          exp_q.push_back("P");
          retire = 1'b1;
        end
      end else begin
        if (!(ic inside {4'h1, 4'h7})) exp_q.push_back("W");
        exp_q.push_back("P");
        retire = 1'b1;
      end
    end

    // ---- cycle-by-cycle drive and compare ----
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs_stage() !== "-" || busy !== 1'b0 || bus.mem_we !== 1'b0 || cc_en !== 1'b0) begin
          bad++;
          $display("FAIL abort_enables got=%c busy=%b we=%b cc=%b exp=- 0 0 0",
                   obs_stage(), busy, bus.mem_we, cc_en);
        end
        total++;
        if (stat !== 3'd1 || retired !== 32'd0 || icode_q !== 4'h0 || ifun_q !== 4'h0) begin
          bad++;
          $display("FAIL abort_regs got stat=%0d ret=%0d ic=%h fn=%h exp 1 0 0 0",
                   stat, retired, icode_q, ifun_q);
        end
        exp_retired = 0; exp_stat = 3'd1; exp_icode = 4'h0; exp_ifun = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end

      stg = obs_stage();
      total++;
      if (stg !== exp_q[k]) begin
        bad++;
        $display("FAIL stage ic=%h k=%0d got=%c exp=%c", ic, k, stg, exp_q[k]);
      end
      exp_aux = {exp_q[k] == "E" && ic == 4'h6,
                 exp_q[k] == "M" && (ic inside {4'h4, 4'h8, 4'hA}),
                 1'b1};
      got_aux = {cc_en, bus.mem_we, busy};
      total++;
      if (got_aux !== exp_aux) begin
        bad++;
        $display("FAIL cc_we_busy ic=%h k=%0d got=%b exp=%b", ic, k, got_aux, exp_aux);
      end

      // Unqualified inputs carry noise; only the qualified cycle is meaningful.
      start           = 1'($urandom);
      bus.imem_ready  = (exp_q[k] == "F" || exp_q[k] == "M") ? 1'b0 : 1'($urandom);
      bus.icode       = 4'($urandom);
      bus.ifun        = 4'($urandom);
      bus.instr_valid = 1'($urandom);
      bus.imem_err    = 1'($urandom);
      bus.dmem_ready  = (exp_q[k] == "F" || exp_q[k] == "M") ? 1'b0 : 1'($urandom);
      bus.dmem_err    = 1'($urandom);
      if (exp_q[k] == "F" && k == iw) begin
        bus.imem_ready  = 1'b1;
        bus.icode       = ic;
        bus.ifun        = fn;
        bus.instr_valid = valid;
        bus.imem_err    = ierr;
      end
      if (exp_q[k] == "M") begin
        if (mi == dw) begin
          bus.dmem_ready = 1'b1;
          bus.dmem_err   = derr;
        end
        mi++;
      end
      @(negedge clk);
    end

    start = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    if (iw < TMO) begin
      exp_icode = ic;
      exp_ifun  = fn;
    end
    if (retire) exp_retired++;
    exp_stat = nstat;

    total++;
    if (retired !== 32'(exp_retired)) begin
      bad++;
      $display("FAIL retired ic=%h got=%0d exp=%0d", ic, retired, exp_retired);
    end
    total++;
    if (stat !== exp_stat) begin
      bad++;
      $display("FAIL stat ic=%h got=%0d exp=%0d", ic, stat, exp_stat);
    end
    total++;
    if (icode_q !== exp_icode || ifun_q !== exp_ifun) begin
      bad++;
      $display("FAIL latched_codes got=%h/%h exp=%h/%h", icode_q, ifun_q, exp_icode, exp_ifun);
    end

    // Terminal states ignore start and stay silent.
    if (term) begin
      for (int c = 0; c < 4; c++) begin
        start = (c == 1) ? 1'b1 : 1'($urandom);
        @(negedge clk);
        total++;
        if (obs_stage() !== "-" || busy !== 1'b0 || stat !== exp_stat ||
            retired !== 32'(exp_retired)) begin
          bad++;
          $display("FAIL terminal c=%0d got=%c busy=%b stat=%0d ret=%0d exp=- 0 %0d %0d",
                   c, obs_stage(), busy, stat, retired, exp_stat, exp_retired);
        end
      end
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (obs_stage() !== "-" || busy !== 1'b0 || bus.mem_we !== 1'b0 || cc_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_enables got=%c busy=%b exp=- 0", obs_stage(), busy);
    end
    total++;
    if (stat !== 3'd1 || retired !== 32'd0 || icode_q !== 4'h0 || ifun_q !== 4'h0) begin
      bad++;
      $display("FAIL reset_regs got stat=%0d ret=%0d ic=%h fn=%h exp 1 0 0 0",
               stat, retired, icode_q, ifun_q);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (obs_stage() !== "-") begin
      bad++;
      $display("FAIL idle_without_start got=%c exp=-", obs_stage());
    end
  endtask

  task automatic test_nop();
    apply_reset_start();
    run_instr(4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic test_opq();
    run_instr(4'h6, 4'h1, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    run_instr(4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    run_instr(4'h7, 4'h3, 1'b1, 1'b0, 1'b0, 1, 0, -1);
  endtask

  task automatic test_mrmovq_wait();
    run_instr(4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 0, 3, -1);
    run_instr(4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 3, 0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_instr(4'($urandom_range(1, 11)), 4'($urandom), 1'b1, 1'b0, 1'b0,
                $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end
  endtask

  task automatic test_halt();
    run_instr(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1, 0, -1);
  endtask

  task automatic test_illegal();
    apply_reset_start();
    run_instr(4'hC, 4'h0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    apply_reset_start();
    run_instr(4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    apply_reset_start();
    run_instr(4'h3, 4'h0, 1'b1, 1'b1, 1'b0, 2, 0, -1);
  endtask

  task automatic test_dmem_err();
    apply_reset_start();
    run_instr(4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    run_instr(4'hA, 4'h0, 1'b1, 1'b0, 1'b1, 0, 1, -1);
  endtask

  task automatic test_timeout();
    apply_reset_start();
    run_instr(4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 0, TMO, -1);
    apply_reset_start();
    run_instr(4'h1, 4'h0, 1'b1, 1'b0, 1'b0, TMO, 0, -1);
  endtask

  task automatic test_reset_mid_mem();
    apply_reset_start();
    run_instr(4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    run_instr(4'h6, 4'h2, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    // Trace F D E M M ...: reset lands in the second MEM cycle.
    run_instr(4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 0, TMO, 4);
    total++;
    if (obs_stage() !== "-" || stat !== 3'd1 || retired !== 32'd0) begin
      bad++;
      $display("FAIL after_mid_reset got=%c stat=%0d ret=%0d exp=- 1 0",
               obs_stage(), stat, retired);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.imem_ready = 1'b0; bus.icode = 4'h0; bus.ifun = 4'h0;
    bus.instr_valid = 1'b0; bus.imem_err = 1'b0;
    bus.dmem_ready = 1'b0; bus.dmem_err = 1'b0;
    exp_retired = 0; exp_stat = 3'd1; exp_icode = 4'h0; exp_ifun = 4'h0;
    test_reset();
    test_nop();
    test_opq();
    test_mrmovq_wait();
    test_random();
    test_halt();
    test_illegal();
    test_dmem_err();
    test_timeout();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
